// File: rtl/tag_alloc_pkg.sv
// tag_alloc_pkg: shared defaults for the tag allocator slice
package tag_alloc_pkg;
  localparam int N_DEF = 8;
endpackage

// File: rtl/tag_alloc_dec.sv
// dec: binary index to one-hot, all-zero when disabled or out of range
module dec #(
  parameter int N = 8
) (
  input  logic                 i_en,
  input  logic [$clog2(N)-1:0] i_idx,
  output logic [N-1:0]         o_oh
);
  assign o_oh = i_en ? N'(1) << i_idx : '0;
endmodule

// File: rtl/tag_alloc_pri_enc.sv
// pri_enc: lowest-set-bit encoder with valid flag
module pri_enc #(
  parameter int N = 8
) (
  input  logic [N-1:0]         i_vec,
  output logic                 o_vld,
  output logic [$clog2(N)-1:0] o_idx
);
  localparam int W = $clog2(N);
  assign o_vld = |i_vec;
  always_comb begin
    o_idx = '0;
    for (int i = N - 1; i >= 0; i--) o_idx = i_vec[i] ? W'(i) : o_idx;
  end
endmodule

// File: rtl/tag_alloc.sv
// tag_alloc: lowest-free-index tag pool with registered alloc and free ports
module tag_alloc
  import tag_alloc_pkg::*;
#(
  parameter int N = N_DEF
) (
  input  logic                   clk,
  input  logic                   rst_n,
  output logic                   o_alloc_vld,
  output logic [$clog2(N)-1:0]   o_alloc_tag,
  input  logic                   i_alloc_acc,
  input  logic                   i_free_vld,
  input  logic [$clog2(N)-1:0]   i_free_tag,
  output logic [N-1:0]           o_busy,
  output logic [$clog2(N+1)-1:0] o_cnt,
  output logic                   o_full,
  output logic                   o_err_dbl_free
);
  localparam int W = $clog2(N);
  localparam int CW = $clog2(N + 1);
  logic [N-1:0] busy_r, busy_nxt, alloc_oh, free_oh;
  logic [CW-1:0] cnt_r, cnt_nxt;
  logic fire, legal, nxt_vld;
  logic [W-1:0] nxt_tag;
  assign fire = o_alloc_vld & i_alloc_acc;
  dec #(.N(N)) u_alloc_dec (.i_en(fire), .i_idx(o_alloc_tag), .o_oh(alloc_oh));
  dec #(.N(N)) u_free_dec (.i_en(i_free_vld), .i_idx(i_free_tag), .o_oh(free_oh));
  // free_oh is empty for out-of-range tags, so this also covers the range check
  always_comb begin
    legal = |(free_oh & busy_r);
    busy_nxt = (busy_r | alloc_oh) & ~(legal ? free_oh : '0);
    cnt_nxt = cnt_r + CW'(fire) - CW'(legal);
  end
  pri_enc #(.N(N)) u_pri (.i_vec(~busy_nxt), .o_vld(nxt_vld), .o_idx(nxt_tag));
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy_r <= '0;
      cnt_r <= '0;
      o_full <= 1'b0;
      o_alloc_vld <= 1'b0;
      o_alloc_tag <= '0;
      o_err_dbl_free <= 1'b0;
    end else begin
      busy_r <= busy_nxt;
      cnt_r <= cnt_nxt;
      o_full <= cnt_nxt == CW'(N);
      o_alloc_vld <= nxt_vld;
      o_alloc_tag <= nxt_tag;
      o_err_dbl_free <= i_free_vld & ~legal;
    end
  end
  assign o_busy = busy_r;
  assign o_cnt = cnt_r;
  a_full_vld: assert property (@(posedge clk) disable iff (!rst_n) !(o_full && o_alloc_vld));
  a_cnt_pop: assert property (@(posedge clk) disable iff (!rst_n) cnt_r == CW'($countones(busy_r)));
  a_tag_free: assert property (@(posedge clk) disable iff (!rst_n) o_alloc_vld |-> !busy_r[o_alloc_tag]);
endmodule

// File: tb/tb_tag_alloc.sv
// tb_tag_alloc: directed and randomized checks of tag_alloc against a pool model
module tb_tag_alloc;
  localparam int N = 8;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic acc = 1'b0;
  logic free_vld = 1'b0;
  logic [2:0] free_tag = '0;
  logic vld, full, err;
  logic [2:0] tag;
  logic [N-1:0] busy;
  logic [3:0] cnt;
  int errors = 0;
  int checks = 0;
  bit busy_m[N];
  bit vld_m, err_m;
  int tag_m;
  tag_alloc #(.N(N)) dut (
    .clk(clk), .rst_n(rst_n), .o_alloc_vld(vld), .o_alloc_tag(tag),
    .i_alloc_acc(acc), .i_free_vld(free_vld), .i_free_tag(free_tag),
    .o_busy(busy), .o_cnt(cnt), .o_full(full), .o_err_dbl_free(err)
  );
  always #5 clk = ~clk;
  function automatic int pop_m();
    int c = 0;
    for (int i = 0; i < N; i++) c += int'(busy_m[i]);
    return c;
  endfunction
  function automatic logic [N-1:0] mask_m();
    logic [N-1:0] m = '0;
    for (int i = 0; i < N; i++) m[i] = busy_m[i];
    return m;
  endfunction
  task automatic cyc(input bit r, input bit a, input bit fv, input int ft);
    bit fire, legal;
    rst_n = r; acc = a; free_vld = fv; free_tag = 3'(ft);
    @(posedge clk);
    if (!r) begin
      foreach (busy_m[i]) busy_m[i] = 0;
      vld_m = 0; tag_m = 0; err_m = 0;
    end else begin
      fire = vld_m && a;
      legal = fv && ft < N && busy_m[ft];
      if (fire) busy_m[tag_m] = 1;
      if (legal) busy_m[ft] = 0;
      err_m = fv && !legal;
      vld_m = 0; tag_m = 0;
      for (int i = N - 1; i >= 0; i--) if (!busy_m[i]) begin vld_m = 1; tag_m = i; end
    end
    #1;
  endtask
  task automatic test_reset();
    cyc(0, 1, 1, 2);
    cyc(0, 1, 1, 2);
    checks++;
    if (busy !== 8'h00 || cnt !== 4'd0 || vld !== 1'b0 || tag !== 3'd0 || err !== 1'b0 || full !== 1'b0) begin
      errors++;
      $display("FAIL reset: busy=%h cnt=%0d vld=%b tag=%0d err=%b full=%b, need 00/0/0/0/0/0", busy, cnt, vld, tag, err, full);
    end
  endtask
  task automatic test_fill();
    for (int k = 1; k <= 9; k++) begin
      cyc(1, 1, 0, 0);
      checks++;
      if (k <= 8 && (vld !== 1'b1 || tag !== 3'(k - 1) || full !== 1'b0)) begin
        errors++;
        $display("FAIL fill cycle %0d: vld=%b tag=%0d full=%b, need 1/%0d/0", k, vld, tag, full, k - 1);
      end
      if (k == 9 && (vld !== 1'b0 || full !== 1'b1 || busy !== 8'hFF || cnt !== 4'd8)) begin
        errors++;
        $display("FAIL fill end: vld=%b full=%b busy=%h cnt=%0d, need 0/1/ff/8", vld, full, busy, cnt);
      end
    end
  endtask
  task automatic test_free_full();
    cyc(1, 0, 1, 5);
    checks++;
    if (vld !== 1'b1 || tag !== 3'd5 || cnt !== 4'd7 || busy !== 8'hDF || full !== 1'b0) begin
      errors++;
      $display("FAIL free_full: vld=%b tag=%0d cnt=%0d busy=%h full=%b, need 1/5/7/df/0", vld, tag, cnt, busy, full);
    end
    cyc(1, 1, 0, 0);
    checks++;
    if (busy !== 8'hFF || cnt !== 4'd8 || full !== 1'b1 || vld !== 1'b0) begin
      errors++;
      $display("FAIL refill: busy=%h cnt=%0d full=%b vld=%b, need ff/8/1/0", busy, cnt, full, vld);
    end
  endtask
  task automatic test_simul();
    cyc(0, 0, 0, 0);
    cyc(1, 0, 0, 0);
    repeat (4) cyc(1, 1, 0, 0);
    checks++;
    if (busy !== 8'h0F || tag !== 3'd4 || vld !== 1'b1) begin
      errors++;
      $display("FAIL simul setup: busy=%h tag=%0d vld=%b, need 0f/4/1", busy, tag, vld);
    end
    cyc(1, 1, 1, 1);
    checks++;
    if (busy !== 8'h1D || cnt !== 4'd4 || tag !== 3'd1 || err !== 1'b0) begin
      errors++;
      $display("FAIL simul: busy=%h cnt=%0d tag=%0d err=%b, need 1d/4/1/0", busy, cnt, tag, err);
    end
  endtask
  task automatic test_dbl_free();
    cyc(1, 0, 1, 6);
    checks++;
    if (err !== 1'b1 || busy !== 8'h1D || cnt !== 4'd4) begin
      errors++;
      $display("FAIL dbl_free: err=%b busy=%h cnt=%0d, need 1/1d/4", err, busy, cnt);
    end
    cyc(1, 0, 0, 0);
    checks++;
    if (err !== 1'b0) begin
      errors++;
      $display("FAIL dbl_free pulse: err=%b, need 0", err);
    end
  endtask
  task automatic test_free_accepting();
    cyc(1, 1, 1, 1);
    checks++;
    if (err !== 1'b1 || busy !== 8'h1F || cnt !== 4'd5 || tag !== 3'd5) begin
      errors++;
      $display("FAIL free_accepting: err=%b busy=%h cnt=%0d tag=%0d, need 1/1f/5/5", err, busy, cnt, tag);
    end
  endtask
  task automatic test_midreset();
    cyc(0, 0, 0, 0);
    cyc(1, 0, 0, 0);
    repeat (8) cyc(1, 1, 0, 0);
    for (int t = 0; t < N; t += 2) cyc(1, 0, 1, t);
    checks++;
    if (busy !== 8'hAA || cnt !== 4'd4) begin
      errors++;
      $display("FAIL midreset setup: busy=%h cnt=%0d, need aa/4", busy, cnt);
    end
    cyc(0, 1, 1, 1);
    checks++;
    if (busy !== 8'h00 || cnt !== 4'd0 || vld !== 1'b0 || full !== 1'b0 || err !== 1'b0) begin
      errors++;
      $display("FAIL midreset: busy=%h cnt=%0d vld=%b full=%b err=%b, need 00/0/0/0/0", busy, cnt, vld, full, err);
    end
    cyc(1, 0, 0, 0);
    checks++;
    if (vld !== 1'b1 || tag !== 3'd0 || busy !== 8'h00) begin
      errors++;
      $display("FAIL midreset release: vld=%b tag=%0d busy=%h, need 1/0/00", vld, tag, busy);
    end
  endtask
  task automatic test_random();
    for (int c = 0; c < 10000; c++) begin
      cyc($urandom_range(0, 499) != 0, $urandom_range(0, 1) == 1, $urandom_range(0, 2) == 0, int'($urandom_range(0, N - 1)));
      checks++;
      if (busy !== mask_m() || cnt !== 4'(pop_m()) || full !== (pop_m() == N) || err !== err_m || vld !== vld_m || (vld_m && tag !== 3'(tag_m))) begin
        errors++;
        $display("FAIL random cycle %0d: busy=%h cnt=%0d full=%b err=%b vld=%b tag=%0d, need %h/%0d/%b/%b/%b/%0d",
                 c, busy, cnt, full, err, vld, tag, mask_m(), pop_m(), pop_m() == N, err_m, vld_m, tag_m);
      end
    end
  endtask
  initial begin
    test_reset();
    test_fill();
    test_free_full();
    test_simul();
    test_dbl_free();
    test_free_accepting();
    test_midreset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
